// File: rtl/spi_xfer_queue.sv
// Byte-level queueing front end for the SPI master core.
// The host pushes bytes into a TX FIFO. Each byte is launched as one SPI
// transfer, and the byte the master receives lands in an RX FIFO that the
// host drains. A launch only happens when RX has room, so a received byte
// can never be dropped.

module spi_xfer_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   spi_start,
    output logic [7:0]             spi_din,
    input  logic                   spi_done,
    input  logic [7:0]             spi_dout,
    output logic                   busy,
    output logic                   tx_ovf,
    output logic                   rx_udf,
    output logic                   timeout,
    input  logic                   clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t r_state;

    // TX FIFO storage and bookkeeping
    logic [7:0]    r_txMem [DEPTH];
    logic [AW-1:0] r_txWrPtr;
    logic [AW-1:0] r_txRdPtr;
    logic [CW-1:0] r_txCount;

    // RX FIFO storage and bookkeeping
    logic [7:0]    r_rxMem [DEPTH];
    logic [AW-1:0] r_rxWrPtr;
    logic [AW-1:0] r_rxRdPtr;
    logic [CW-1:0] r_rxCount;

    // Transfer engine registers
    logic          r_spiStart;
    logic [7:0]    r_spiDin;
    logic [TW-1:0] r_timer;

    // Sticky error flags
    logic          r_txOvf;
    logic          r_rxUdf;
    logic          r_timeout;

    logic w_txFull;
    logic w_txEmpty;
    logic w_rxFull;
    logic w_rxEmpty;
    logic w_launch;
    logic w_txPush;
    logic w_txPop;
    logic w_doneAccept;
    logic w_timeoutHit;
    logic w_rxPush;
    logic w_rxPop;

    assign w_txFull  = (r_txCount == FULL_COUNT);
    assign w_txEmpty = (r_txCount == '0);
    assign w_rxFull  = (r_rxCount == FULL_COUNT);
    assign w_rxEmpty = (r_rxCount == '0);

    // A new transfer needs a queued byte and a free RX slot for its reply
    assign w_launch = (r_state == IDLE) && !w_txEmpty && !w_rxFull;
    assign w_txPop  = w_launch;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_txPush = wr_en && (!w_txFull || w_txPop);

    // done is ignored during the start cycle, and beats a coincident timeout
    assign w_doneAccept = (r_state == XFER) && !r_spiStart && spi_done;
    assign w_timeoutHit = (r_state == XFER) && !w_doneAccept && (r_timer == TIMER_MAX);

    assign w_rxPush = w_doneAccept && !w_rxFull;
    assign w_rxPop  = rd_en && !w_rxEmpty;

    // TX payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_txPush) begin
            r_txMem[r_txWrPtr] <= wr_data;
        end
    end

    // TX pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) begin
                r_txWrPtr <= r_txWrPtr + AW'(1);
            end
            if (w_txPop) begin
                r_txRdPtr <= r_txRdPtr + AW'(1);
            end
            case ({w_txPush, w_txPop})
                2'b10:   r_txCount <= r_txCount + CW'(1);
                2'b01:   r_txCount <= r_txCount - CW'(1);
                default: r_txCount <= r_txCount;
            endcase
        end
    end

    // RX payload storage; the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (w_rxPush) begin
            r_rxMem[r_rxWrPtr] <= spi_dout;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) begin
                r_rxWrPtr <= r_rxWrPtr + AW'(1);
            end
            if (w_rxPop) begin
                r_rxRdPtr <= r_rxRdPtr + AW'(1);
            end
            case ({w_rxPush, w_rxPop})
                2'b10:   r_rxCount <= r_rxCount + CW'(1);
                2'b01:   r_rxCount <= r_rxCount - CW'(1);
                default: r_rxCount <= r_rxCount;
            endcase
        end
    end

    // Transfer FSM: launch a queued byte, then wait for done or give up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_spiStart <= 1'b0;
            r_spiDin   <= 8'h00;
            r_timer    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_spiStart <= 1'b0;
                    if (w_launch) begin
                        r_state    <= XFER;
                        r_spiDin   <= r_txMem[r_txRdPtr];
                        r_spiStart <= 1'b1;
                        r_timer    <= '0;
                    end
                end
                XFER: begin
                    r_spiStart <= 1'b0;
                    if (w_doneAccept || w_timeoutHit) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_spiStart <= 1'b0;
                    r_timer    <= '0;
                end
            endcase
        end
    end

    // Sticky flags; a new event in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txOvf   <= 1'b0;
            r_rxUdf   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (wr_en && !w_txPush) begin
                r_txOvf <= 1'b1;
            end else if (clr_flags) begin
                r_txOvf <= 1'b0;
            end

            if (rd_en && w_rxEmpty) begin
                r_rxUdf <= 1'b1;
            end else if (clr_flags) begin
                r_rxUdf <= 1'b0;
            end

            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end else if (clr_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign tx_full   = w_txFull;
    assign tx_count  = r_txCount;
    assign rx_empty  = w_rxEmpty;
    assign rx_count  = r_rxCount;
    assign rd_data   = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRdPtr];
    assign spi_start = r_spiStart;
    assign spi_din   = r_spiDin;
    assign busy      = (r_state == XFER);
    assign tx_ovf    = r_txOvf;
    assign rx_udf    = r_rxUdf;
    assign timeout   = r_timeout;

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Byte-level front end for the SPI master core (spi_N).
- Host pushes transmit bytes into a TX FIFO. The block launches one SPI byte transfer per queued byte, holds the byte on the master's data input, and waits for the master's done.
- Each received byte is captured into an RX FIFO that the host drains.
- Sits directly upstream of the SPI master's din/done interface and downstream of the host/register logic.

Parameters:
DEPTH, 4, entries in each of TX and RX FIFO; must be a power of two, at least 2
TIMEOUT, 64, max cycles to wait for spi_done after spi_start before aborting; at least 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push wr_data into TX FIFO
wr_data  input  8  byte to transmit
tx_full  output  1  TX FIFO holds DEPTH entries
tx_count  output  $clog2(DEPTH)+1  TX FIFO occupancy
rd_en  input  1  pop head of RX FIFO
rd_data  output  8  RX FIFO head (first-word-fall-through)
rx_empty  output  1  RX FIFO holds 0 entries
rx_count  output  $clog2(DEPTH)+1  RX FIFO occupancy
spi_start  output  1  one-cycle pulse to SPI master: begin transfer
spi_din  output  8  byte to SPI master, stable for the whole transfer
spi_done  input  1  SPI master transfer complete
spi_dout  input  8  byte received by SPI master, valid when spi_done=1
busy  output  1  high while state is XFER
tx_ovf  output  1  sticky: write attempted while tx_full
rx_udf  output  1  sticky: read attempted while rx_empty
timeout  output  1  sticky: transfer aborted by timeout
clr_flags  input  1  synchronous clear of tx_ovf, rx_udf, timeout

Behaviour:
- Reset (asynchronous): both FIFOs empty; pointers and counts 0.
  - tx_full=0, rx_empty=1, rd_data=0, spi_start=0, spi_din=0, busy=0.
  - All sticky flags 0; state IDLE; timeout counter 0.
  - Asserting reset mid-transfer aborts immediately. The in-flight byte is lost and no RX write occurs.
- TX FIFO write:
  - wr_en with !tx_full stores wr_data at the edge; tx_count increments next cycle.
  - wr_en with tx_full drops the data and sets tx_ovf.
  - A write and an FSM pop in the same cycle are both performed, so tx_count is unchanged. This holds even when tx_full=1, because the write is accepted in that case.
- RX FIFO read:
  - rd_data shows the head whenever !rx_empty, and 0 when empty.
  - rd_en with !rx_empty advances the head at the edge.
  - rd_en with rx_empty is ignored and sets rx_udf.
  - An FSM write and a host read in the same cycle are both performed.
- Pointers wrap modulo DEPTH. Full/empty are derived from the counts.
- FSM states: IDLE, XFER.
  - IDLE -> XFER when tx_count!=0 and rx_count<DEPTH. Reserving RX space guarantees that no received byte is ever dropped.
  - On that edge: pop the TX head into the spi_din register, set spi_start=1 and clear the counter.
  - spi_start is high only in the first XFER cycle and low otherwise.
  - spi_din holds its value until the next launch and is never changed during XFER.
- XFER behaviour:
  - spi_done is ignored in the spi_start cycle. The timeout counter increments every XFER cycle.
  - spi_done=1 in any later XFER cycle: write spi_dout to the RX FIFO at that edge, go to IDLE, clear the counter.
  - If the counter reaches TIMEOUT-1 with no spi_done: go to IDLE, set timeout, no RX write.
  - If spi_done and the timeout coincide, done wins.
- Throughput: done sampled in cycle k gives IDLE in k+1; if conditions hold, the next spi_start is in k+2. The minimum spacing from spi_done to the next spi_start is therefore 2 cycles.
- spi_done seen in IDLE is ignored.
- busy = (state==XFER).
- clr_flags clears the sticky flags. If a flag-setting event occurs in the same cycle, the set wins.

Test Plan:
- Reset then write 8'hAA; stub master returns spi_done with spi_dout=8'hCC 8 cycles after spi_start -> spi_start pulses once, spi_din=8'hAA, busy for 9 cycles, rx_count=1, rd_data=8'hCC, tx_count=0.
- Write 8'h01,02,03,04 back-to-back; stub echoes din+8'h10 -> four transfers, spi_start pulses exactly 2 cycles after each done, RX reads 11,12,13,14 in order.
- Fill TX with DEPTH=4 bytes while the master is stalled, then write a fifth -> tx_ovf=1, fifth byte never transmitted; clr_flags -> tx_ovf=0.
- Leave RX full (4 entries) with TX holding 8'h55 -> no spi_start; one rd_en -> spi_start in the cycle after rx_count becomes 3.
- Stub never asserts done -> after 64 XFER cycles state is IDLE, timeout=1, rx_count unchanged, next queued byte launches.
- Assert rst in the middle of a transfer -> all outputs return to reset values immediately; a late spi_done after reset causes no RX write.
